// File: rtl/aes_stream_sequencer.sv
// Stream front/back end for a fixed-latency pipelined aes_128 core: registers
// accepted blocks onto the core, tracks them with a tag pipeline and buffers results.
module aes_stream_sequencer #(
  parameter int LATENCY = 21,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [127:0]                 in_plaintext,
  input  logic [127:0]                 in_key,
  output logic [127:0]                 core_state,
  output logic [127:0]                 core_key,
  input  logic [127:0]                 core_ct,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [127:0]                 out_data,
  output logic [$clog2(DEPTH+1)-1:0]   inflight,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic [CNT_W-1:0]             blk_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [127:0]     state_reg;
  logic [127:0]     key_reg;
  logic             accept_reg;
  logic [LATENCY-1:0] tag_reg;
  logic [CW-1:0]    inflight_reg, inflight_next;
  logic [CW-1:0]    level_reg, level_next;
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [127:0]     mem_reg [DEPTH];
  logic [CNT_W-1:0] blk_count_reg;

  logic             accept;
  logic             capture;
  logic             pop;
  logic [CW:0]      credit_used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits count blocks in the core plus blocks buffered, so a capture always has a free slot.
  assign credit_used = {1'b0, inflight_reg} + {1'b0, level_reg};
  assign in_ready    = rst && (credit_used < (CW+1)'(DEPTH));
  assign accept      = in_valid && in_ready;
  assign capture     = tag_reg[LATENCY-1];
  assign out_valid   = (level_reg != '0);
  assign pop         = out_valid && out_ready;

  always_comb begin
    inflight_next = inflight_reg;
    level_next    = level_reg;
    if (accept && !capture) begin
      inflight_next = inflight_reg + CW'(1);
    end else if (!accept && capture) begin
      inflight_next = inflight_reg - CW'(1);
    end
    if (capture && !pop) begin
      level_next = level_reg + CW'(1);
    end else if (!capture && pop) begin
      level_next = level_reg - CW'(1);
    end
  end

  // tag[0] marks the block currently presented on core_state, one edge after accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= '0;
      key_reg      <= '0;
      accept_reg   <= 1'b0;
      tag_reg      <= '0;
      inflight_reg <= '0;
    end else begin
      if (accept) begin
        state_reg <= in_plaintext;
        key_reg   <= in_key;
      end
      accept_reg   <= accept;
      tag_reg      <= {tag_reg[LATENCY-2:0], accept_reg};
      inflight_reg <= inflight_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (capture) begin
        mem_reg[wr_ptr_reg] <= core_ct;
        wr_ptr_reg          <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      level_reg <= level_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      blk_count_reg <= '0;
    end else if (pop) begin
      blk_count_reg <= blk_count_reg + CNT_W'(1);
    end
  end

  assign core_state = state_reg;
  assign core_key   = key_reg;
  assign out_data   = mem_reg[rd_ptr_reg];
  assign inflight   = inflight_reg;
  assign fifo_level = level_reg;
  assign blk_count  = blk_count_reg;

endmodule

// File: doc/aes_stream_sequencer.md
Name: aes_stream_sequencer

Overview:
- Sits directly upstream and downstream of the pipelined aes_128 core.
- Accepts plaintext/key blocks over a valid/ready handshake and registers them onto the core inputs.
- Tracks each block through the fixed core latency with a tag pipeline, then captures the ciphertext into a small output FIFO with its own valid/ready handshake.
- Credit-based admission ensures a result is never dropped, even when the consumer stalls.

Parameters:
- LATENCY, 21, cycles from a value on core_state/core_key to the matching ciphertext on core_ct.
- DEPTH, 4, output FIFO entries; also the maximum number of blocks in flight plus buffered.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous reset, active-low (rst==0 resets on the next rising edge)
- in_valid  in  1  upstream block valid
- in_ready  out  1  block accepted on a cycle where in_valid && in_ready
- in_plaintext  in  128  plaintext block
- in_key  in  128  cipher key for this block
- core_state  out  128  registered plaintext driven into aes_128
- core_key  out  128  registered key driven into aes_128
- core_ct  in  128  ciphertext from aes_128
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- out_data  out  128  FIFO head ciphertext
- inflight  out  $clog2(DEPTH+1)  blocks in the core pipeline
- fifo_level  out  $clog2(DEPTH+1)  FIFO occupancy
- blk_count  out  CNT_W  ciphertexts delivered (popped), wraps modulo 2^CNT_W

Behaviour:
- Reset (rst==0 at a clock edge):
  - core_state, core_key, out_data and blk_count are 0.
  - The tag pipeline is cleared; inflight, fifo_level and out_valid are 0.
  - The FIFO pointers are 0.
  - Reset has priority over every other event in the same cycle.
- Admission:
  - in_ready = (inflight + fifo_level) < DEPTH, computed combinationally from registered counts only.
  - A pop in the same cycle does not add credit until the next cycle.
  - in_ready is 0 while rst==0.
- Accept (in_valid && in_ready at edge T):
  - core_state <= in_plaintext and core_key <= in_key at edge T.
  - A 1 is shifted into tag[0]; otherwise a 0 is shifted in and core_state/core_key hold their values.
- Tag pipeline:
  - LATENCY-bit shift register, advancing every cycle unconditionally.
  - tag[LATENCY-1]==1 marks that core_ct currently holds the ciphertext of the block accepted LATENCY cycles earlier.
  - In that cycle core_ct is pushed into the FIFO at the next edge.
  - Net latency from accept edge to out_valid rising = LATENCY+1 edges when the FIFO is empty.
- inflight:
  - Increments on accept and decrements on capture.
  - Both in the same cycle leaves it unchanged.
  - It never exceeds DEPTH.
- FIFO:
  - DEPTH-entry circular buffer; write and read pointers wrap from DEPTH-1 to 0.
  - out_valid = (fifo_level != 0); out_data = entry at the read pointer.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leaves fifo_level unchanged.
  - Push when full cannot occur by construction (credit rule); the bench asserts this.
  - Pop when empty is ignored.
- blk_count increments on each pop and wraps from 2^CNT_W-1 to 0.
- Reset mid-operation:
  - All in-flight blocks and FIFO contents are discarded.
  - The core's stale internal pipeline produces no captures because the tags are cleared.
- Back-to-back: one block per cycle is sustained while out_ready==1 and credits allow.
- Consumer stall: with out_ready==0 at most DEPTH blocks are admitted, then in_ready stays 0 until a pop occurs.

Test Plan:
- Single FIPS-197 vector: key=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff, out_ready=1 -> out_valid rises LATENCY+1 edges after accept with out_data=69c4e0d86a7b0430d8cdb78070b4c55a; blk_count=1 after pop.
- Four back-to-back blocks (FIPS vector, then pt+1, pt+2, pt+3 with the same key), out_ready=1 -> four consecutive out_valid cycles in order; each out_data matches the reference model; inflight peaks at 4.
- Stall: out_ready=0, in_valid held 1 for 10 cycles -> exactly 4 accepts, then in_ready=0; fifo_level reaches 4; raising out_ready for 1 cycle pops one entry, and in_ready returns 1 on the following cycle.
- Simultaneous push/pop with FIFO at level 2 -> fifo_level stays 2, data order is preserved, and the pointers wrap correctly over 12 blocks.
- Reset mid-operation: assert rst=0 for 1 cycle with 3 blocks in flight -> next cycle out_valid=0, inflight=0, fifo_level=0, blk_count=0, and no capture occurs in the following LATENCY+2 cycles.
- Counter wrap: force blk_count to 0xFFFF (CNT_W=16), then pop one block -> blk_count=0x0000.
